// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - Default widths, kept equal to the widths alu_top is built with.
//   - ALU mode encodings as seen on alu_top mode_sel.
//   - Sequencer FSM state type.
//   - Helper deciding which carry is reported back to the requester.
package alu_seq_ctrl_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_OPT_W  = 4;
  localparam int DEF_CNT_W  = 8;

  localparam logic [1:0] MODE_ARITH   = 2'b00;
  localparam logic [1:0] MODE_LOGIC   = 2'b01;
  localparam logic [1:0] MODE_COMP    = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Only arithmetic ops produce a meaningful carry; other modes report 0
  // regardless of what alu_top drives on Cout.
  function automatic logic carry_keep(input logic [1:0] mode, input logic cout);
    return (mode == MODE_ARITH) && cout;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer in front of the combinational 4-bit ALU.
//
// Flow: IDLE accepts one command (valid/ready) and registers it onto the
// alu_* pins; EXEC gives the ALU one full cycle and captures its result;
// RESP presents the result until the consumer takes it. The last legal
// result is kept in an accumulator so a chained command can use it as A.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_a, cmd_b, cmd_opt      operands and ALU option code
//   cmd_mode                   00 arith, 01 logic, 10 compare/shift, 11 illegal
//   cmd_chain                  use accumulator as operand A
//   acc_clr                    clear accumulator (any state)
//   alu_operand_a/b, alu_option, alu_mode_sel   registered ALU inputs
//   alu_data, alu_cout         ALU result inputs
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_carry, rsp_err  captured response
//   busy                       state != IDLE
//   done_cnt                   completed response handshakes (wrapping)
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OPT_W  = DEF_OPT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OPT_W-1:0]  cmd_opt,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_chain,
  input  logic              acc_clr,
  output logic [DATA_W-1:0] alu_operand_a,
  output logic [DATA_W-1:0] alu_operand_b,
  output logic [OPT_W-1:0]  alu_option,
  output logic [1:0]        alu_mode_sel,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_cout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  state_e            state;
  logic [DATA_W-1:0] acc;
  logic              illegal;

  // Ready is gated by rst_n so no command is taken while reset is held.
  assign cmd_ready = (state == ST_IDLE) && rst_n;
  assign busy      = (state != ST_IDLE);

  // The registered mode is what the ALU is executing this cycle.
  assign illegal   = (alu_mode_sel == MODE_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_option    <= '0;
      alu_mode_sel  <= MODE_ARITH;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_carry     <= 1'b0;
      rsp_err       <= 1'b0;
      acc           <= '0;
      done_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // acc here is the pre-clear value even if acc_clr is high now.
            alu_operand_a <= cmd_chain ? acc : cmd_a;
            alu_operand_b <= cmd_b;
            alu_option    <= cmd_opt;
            alu_mode_sel  <= cmd_mode;
            state         <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (illegal) begin
            // Result pins are not sampled; accumulator is left untouched.
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b1;
          end else begin
            rsp_data  <= alu_data;
            rsp_carry <= carry_keep(alu_mode_sel, alu_cout);
            rsp_err   <= 1'b0;
            acc       <= alu_data;
          end
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // Placed last so a clear beats the EXEC capture in the same cycle.
      if (acc_clr) acc <= '0;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural stand-in for alu_top.
// A per-cycle driver predicts the sequencer's handshake behaviour and pushes
// expected responses into a queue; an independent monitor compares every
// presented response against the queue head.
module tb_alu_seq_ctrl;

  localparam int DATA_W = 4;
  localparam int OPT_W  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready;
  logic [DATA_W-1:0] cmd_a = '0, cmd_b = '0;
  logic [OPT_W-1:0]  cmd_opt = '0;
  logic [1:0]        cmd_mode = '0;
  logic              cmd_chain = 1'b0, acc_clr = 1'b0;
  logic [DATA_W-1:0] alu_operand_a, alu_operand_b;
  logic [OPT_W-1:0]  alu_option;
  logic [1:0]        alu_mode_sel;
  logic [DATA_W-1:0] alu_data;
  logic              alu_cout;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry, rsp_err, busy;
  logic [CNT_W-1:0]  done_cnt;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(DATA_W), .OPT_W(OPT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opt(cmd_opt), .cmd_mode(cmd_mode),
    .cmd_chain(cmd_chain), .acc_clr(acc_clr),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_option(alu_option), .alu_mode_sel(alu_mode_sel),
    .alu_data(alu_data), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .done_cnt(done_cnt)
  );

  // Behavioural ALU: {cout, data}. Non-arith modes drive a nonzero Cout on
  // purpose, and mode 11 drives junk data, so masking in the DUT is visible.
  function automatic logic [4:0] alu_fn(input logic [1:0] m, input logic [3:0] o,
                                        input logic [3:0] a, input logic [3:0] b);
    int s;
    logic [3:0] d;
    logic c;
    case (m)
      2'b00: begin
        if (o[0]) begin s = int'(a) - int'(b); c = (s >= 0); s = (s + 16) % 16; end
        else      begin s = int'(a) + int'(b); c = (s > 15);  s = s % 16; end
        d = 4'(s);
      end
      2'b01: begin
        case (o[1:0])
          2'd0: d = a & b;
          2'd1: d = a | b;
          2'd2: d = a ^ b;
          default: d = ~(a & b);
        endcase
        c = 1'b1;
      end
      2'b10: begin
        if (o[0]) begin d = 4'((int'(a) * 2) % 16); c = a[3]; end
        else      begin d = (a > b) ? 4'd1 : 4'd0;   c = 1'b1; end
      end
      default: begin d = a ^ b ^ o; c = 1'b1; end
    endcase
    return {c, d};
  endfunction

  always_comb {alu_cout, alu_data} = alu_fn(alu_mode_sel, alu_option, alu_operand_a, alu_operand_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 executing, 2 responding.
  int         m_phase = 0;
  logic [3:0] m_acc = '0, m_opa = '0, m_b = '0, m_opt = '0;
  logic [1:0] m_mode = '0;
  logic [7:0] m_done = '0;
  logic       d_rst = 1'b0;
  logic [5:0] exp_q[$];   // {err, carry, data}

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] o, input logic [1:0] md,
                      input logic ch, input logic clr, input logic rr);
    logic [4:0] r;
    @(negedge clk);
    rst_n = d_rst; cmd_valid = v; cmd_a = a; cmd_b = b; cmd_opt = o;
    cmd_mode = md; cmd_chain = ch; acc_clr = clr; rsp_ready = rr;
    #1;
    chk("cmd_ready", cmd_ready, rst_n && m_phase == 0);
    chk("busy", busy, m_phase != 0);
    chk("rsp_valid", rsp_valid, m_phase == 2);
    chk("done_cnt", done_cnt, m_done);
    if (m_phase == 1) begin
      chk("alu_operand_a", alu_operand_a, m_opa);
      chk("alu_operand_b", alu_operand_b, m_b);
      chk("alu_option", alu_option, m_opt);
      chk("alu_mode_sel", alu_mode_sel, m_mode);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_acc = '0; m_done = '0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (v) begin
          m_opa = ch ? m_acc : a; m_b = b; m_opt = o; m_mode = md; m_phase = 1;
        end
        1: begin
          if (m_mode == 2'b11) exp_q.push_back({1'b1, 1'b0, 4'h0});
          else begin
            r = alu_fn(m_mode, m_opt, m_opa, m_b);
            exp_q.push_back({1'b0, (m_mode == 2'b00) && r[4], r[3:0]});
            m_acc = r[3:0];
          end
          m_phase = 2;
        end
        default: if (rr) begin m_done = m_done + 8'd1; m_phase = 0; end
      endcase
      if (clr) m_acc = '0;
    end
  endtask

  task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic [3:0] o,
                        input logic [1:0] md, input logic ch);
    step(1'b1, a, b, o, md, ch, 1'b0, 1'b0);
  endtask

  task automatic nop(input logic clr, input logic rr);
    step(1'b0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, clr, rr);
  endtask

  task automatic expect_rsp(input string n, input logic [3:0] d, input logic c, input logic e);
    #1;
    chk({n, "_valid"}, rsp_valid, 1'b1);
    chk({n, "_data"}, rsp_data, d);
    chk({n, "_carry"}, rsp_carry, c);
    chk({n, "_err"}, rsp_err, e);
  endtask

  // Monitor: every presented response must match the queue head, including
  // cycles where it is held under backpressure; pop on handshake.
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q[0];
          chk("sb_data", rsp_data, e[3:0]);
          chk("sb_carry", rsp_carry, e[4]);
          chk("sb_err", rsp_err, e[5]);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] done_before;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_cnt, 8'h00);
    chk("rst_opa", alu_operand_a, 4'h0);
    d_rst = 1'b1;

    // Single arithmetic add with carry out.
    accept(4'h9, 4'h8, 4'h0, 2'b00, 1'b0);
    #1 chk("t2_lat_n1", rsp_valid, 1'b0);
    nop(1'b0, 1'b0);
    expect_rsp("t2", 4'h1, 1'b1, 1'b0);
    nop(1'b0, 1'b1);
    #1 chk("t2_done", done_cnt, 8'h01);

    // Chain on previous result.
    accept(4'h3, 4'h2, 4'h0, 2'b00, 1'b0);
    nop(1'b0, 1'b0);
    expect_rsp("t3a", 4'h5, 1'b0, 1'b0);
    nop(1'b0, 1'b1);
    accept(4'hE, 4'h4, 4'h0, 2'b00, 1'b1);
    #1 chk("t3_chain_opa", alu_operand_a, 4'h5);
    nop(1'b0, 1'b0);
    expect_rsp("t3b", 4'h9, 1'b0, 1'b0);
    nop(1'b0, 1'b1);

    // Illegal mode leaves acc (9) alone.
    accept(4'h7, 4'h7, 4'h0, 2'b11, 1'b0);
    nop(1'b0, 1'b0);
    expect_rsp("t4", 4'h0, 1'b0, 1'b1);
    nop(1'b0, 1'b1);
    accept(4'h0, 4'h0, 4'h0, 2'b00, 1'b1);
    nop(1'b0, 1'b0);
    expect_rsp("t4_acc", 4'h9, 1'b0, 1'b0);
    nop(1'b0, 1'b1);

    // acc_clr in the capture cycle: response keeps result, acc becomes 0.
    accept(4'h3, 4'h4, 4'h0, 2'b00, 1'b0);
    nop(1'b1, 1'b0);
    expect_rsp("t6", 4'h7, 1'b0, 1'b0);
    nop(1'b0, 1'b1);
    accept(4'hA, 4'h5, 4'h0, 2'b00, 1'b1);
    nop(1'b0, 1'b0);
    expect_rsp("t6_acc", 4'h5, 1'b0, 1'b0);
    nop(1'b0, 1'b1);

    // Backpressure: 5 held cycles with ignored commands, then one handshake.
    accept(4'hF, 4'h1, 4'h0, 2'b00, 1'b0);
    nop(1'b0, 1'b0);
    done_before = done_cnt;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'h2, 4'h3, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
      expect_rsp("t5_hold", 4'h0, 1'b1, 1'b0);
    end
    nop(1'b0, 1'b1);
    #1 chk("t5_done_once", done_cnt, done_before + 8'd1);

    // Reset held for 2 cycles while a response is pending.
    accept(4'h2, 4'h2, 4'h0, 2'b00, 1'b0);
    nop(1'b0, 1'b0);
    nop(1'b0, 1'b0);
    d_rst = 1'b0;
    nop(1'b0, 1'b0);
    nop(1'b0, 1'b0);
    #1;
    chk("t1_rsp_valid", rsp_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_done", done_cnt, 8'h00);
    d_rst = 1'b1;
    accept(4'h6, 4'h0, 4'h0, 2'b00, 1'b1);
    nop(1'b0, 1'b0);
    expect_rsp("t1_acc", 4'h0, 1'b0, 1'b0);
    nop(1'b0, 1'b1);

    // Random traffic; long enough for done_cnt to wrap past 8'hFF.
    for (int i = 0; i < 2500; i++)
      step(1'($urandom % 2), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom % 2), ($urandom % 16) == 0, ($urandom % 4) != 0);
    for (int i = 0; i < 4; i++) nop(1'b0, 1'b1);
    chk("wrap_seen", m_done < 8'd200 ? 32'd1 : 32'd0, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
